ballot_controller: RTL
======================

BALLOT_CONTROLLER -- requirements
Module: ballot_controller

Interface
REQ-001 Parameter CTR_WIDTH, default 16, width of votes_cast; equals downstream tally width.
REQ-002 Parameter DB_CYCLES, default 4, consecutive stable cycles needed to accept a debounced button level.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000, idle cycles in ARMED/SELECTED before the ballot is abandoned.
REQ-004 Parameter LOCKOUT_CYCLES, default 8, dead cycles after each cast vote.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 auth_btn  input  1  raw polling-officer authorize button, active-high, asynchronous.
REQ-008 cand_btn  input  4  raw candidate buttons, bit i = candidate i, active-high, asynchronous.
REQ-009 confirm_btn  input  1  raw voter confirm button, active-high, asynchronous.
REQ-010 enable_btn  output  1  vote strobe to tally stage, high exactly one cycle per cast vote.
REQ-011 sel  output  2  candidate index to tally stage, valid whenever enable_btn is high.
REQ-012 ready  output  1  high in ARMED and SELECTED (voter may vote).
REQ-013 votes_cast  output  CTR_WIDTH  count of strobes issued since reset.
REQ-014 timeout_err  output  1  one-cycle pulse when a ballot is abandoned by timeout.
REQ-015 multi_err  output  1  one-cycle pulse when more than one candidate press event occurs in one cycle.

Function
REQ-016 Each raw input shall pass a 2-flop synchronizer, then a debouncer whose output changes only after the synchronized value differs from it for DB_CYCLES consecutive cycles.
REQ-017 A press event shall be a one-cycle pulse on the 0->1 transition of a debounced level; releases generate no events.
REQ-018 FSM states shall be IDLE, ARMED, SELECTED, CAST, LOCKOUT; all transitions occur at the clock edge ending the event cycle.
REQ-019 IDLE: auth press -> ARMED, timer cleared; all other presses ignored.
REQ-020 ARMED: exactly one candidate press -> SELECTED, sel latched to its index, timer cleared; confirm press ignored.
REQ-021 SELECTED: single candidate press -> sel updated to new index, timer cleared, stay SELECTED; confirm press -> CAST.
REQ-022 Confirm and candidate press in the same SELECTED cycle: confirm wins, sel keeps previously latched value.
REQ-023 Two or more candidate presses in one cycle (ARMED or SELECTED): all ignored, multi_err pulses, state and timer unchanged.
REQ-024 ARMED/SELECTED: timer increments each cycle without a qualifying event; when it reaches TIMEOUT_CYCLES-1 -> IDLE, timeout_err pulses, no vote.
REQ-025 CAST: enable_btn = 1 for this single cycle, votes_cast increments by 1 modulo 2^CTR_WIDTH, next state LOCKOUT.
REQ-026 LOCKOUT: enable_btn = 0 for LOCKOUT_CYCLES cycles, then -> IDLE; all presses ignored.
REQ-027 auth press outside IDLE shall be ignored; one authorization yields at most one vote.
REQ-028 sel shall hold its latched value from entry to SELECTED until next entry to SELECTED; never change in CAST or LOCKOUT.
REQ-029 enable_btn shall be low at least LOCKOUT_CYCLES+1 cycles between strobes, guaranteeing a rising edge per vote downstream.
REQ-030 Latency: confirm press event cycle N -> enable_btn high in cycle N+1.
REQ-031 All outputs shall be registered.

Reset
REQ-032 rst_n low shall immediately force state IDLE, enable_btn 0, sel 0, ready 0, votes_cast 0, timeout_err 0, multi_err 0, timers 0, synchronizers and debounced levels 0.
REQ-033 Reset asserted mid-ballot (any state including CAST) shall discard the ballot; no strobe is emitted after release until a new auth/select/confirm sequence.
REQ-034 Buttons held high across reset release shall produce one press event once debounced, treated per current state.

Verification
REQ-035 auth, cand_btn=4'b0100, confirm (each held > DB_CYCLES+2) -> one enable_btn pulse with sel=2, votes_cast=1, ready low thereafter.
REQ-036 auth, cand 0, cand 3, confirm -> single strobe with sel=3; votes_cast=1.
REQ-037 auth, cand_btn=4'b0011 simultaneously -> multi_err pulse, state ARMED, no sel change; then cand 1, confirm -> sel=1 strobe.
REQ-038 auth then no input for TIMEOUT_CYCLES (set 50) -> timeout_err pulse, ready=0, enable_btn never high.
REQ-039 Full vote, then confirm and second auth during LOCKOUT -> no second strobe; auth after LOCKOUT starts new ballot; 2^CTR_WIDTH votes (CTR_WIDTH=4, 16 votes) -> votes_cast wraps to 0.
REQ-040 Glitch on confirm_btn shorter than DB_CYCLES in SELECTED -> no strobe; rst_n low during SELECTED -> all outputs 0, no strobe after release.

Source files
------------

// File: rtl/ballot_controller.sv
// Ballot controller: synchronized, debounced buttons drive an authorize/select/confirm FSM
// that issues exactly one tally strobe per authorized vote.
module ballot_controller #(
    parameter int CTR_WIDTH      = 16,
    parameter int DB_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int LOCKOUT_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 auth_btn,
    input  logic [3:0]           cand_btn,
    input  logic                 confirm_btn,
    output logic                 enable_btn,
    output logic [1:0]           sel,
    output logic                 ready,
    output logic [CTR_WIDTH-1:0] votes_cast,
    output logic                 timeout_err,
    output logic                 multi_err
);

    localparam int NB      = 6;
    localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int TMR_MAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DB_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LAST = TMR_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_SELECTED,
        S_CAST,
        S_LOCKOUT
    } state_t;

    // Button vector layout: {confirm, cand[3:0], auth}
    logic [NB-1:0]   raw_btn;
    logic [NB-1:0]   sync_q1;
    logic [NB-1:0]   sync_q2;
    logic [NB-1:0]   db_level;
    logic [NB-1:0]   db_level_q;
    logic [NB-1:0]   press;
    logic [DB_W-1:0] db_cnt [NB];

    assign raw_btn = {confirm_btn, cand_btn, auth_btn};

    // NOTE: every register here uses <= so all flops sample pre-edge values in parallel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1    <= '0;
            sync_q2    <= '0;
            db_level   <= '0;
            db_level_q <= '0;
            for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
        end else begin
            sync_q1    <= raw_btn;
            sync_q2    <= sync_q1;
            db_level_q <= db_level;
            for (int i = 0; i < NB; i++) begin
                if (sync_q2[i] != db_level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_level[i] <= sync_q2[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign press = db_level & ~db_level_q;

    logic       auth_ev;
    logic       confirm_ev;
    logic [3:0] cand_ev;
    logic       cand_single;
    logic       cand_multi;
    logic [1:0] cand_idx;

    assign auth_ev     = press[0];
    assign cand_ev     = press[4:1];
    assign confirm_ev  = press[5];
    assign cand_single = ($countones(cand_ev) == 1);
    assign cand_multi  = ($countones(cand_ev) > 1);

    always_comb begin
        cand_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (cand_ev[i]) cand_idx = 2'(i);
        end
    end

    state_t           state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [1:0]       sel_n;
    logic             timeout_n;
    logic             multi_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
        end
    end

    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        sel_n     = sel;
        timeout_n = 1'b0;
        multi_n   = 1'b0;
        unique case (state)
            S_IDLE: begin
                timer_n = '0;
                if (auth_ev) state_n = S_ARMED;
            end
            S_ARMED: begin
                if (cand_multi) begin
                    multi_n = 1'b1;
                end else if (cand_single) begin
                    state_n = S_SELECTED;
                    sel_n   = cand_idx;
                    timer_n = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    state_n   = S_IDLE;
                    timer_n   = '0;
                    timeout_n = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            S_SELECTED: begin
                // Confirm beats any same-cycle candidate press; sel keeps the choice being cast.
                if (confirm_ev) begin
                    state_n = S_CAST;
                    timer_n = '0;
                    multi_n = cand_multi;
                end else if (cand_multi) begin
                    multi_n = 1'b1;
                end else if (cand_single) begin
                    sel_n   = cand_idx;
                    timer_n = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    state_n   = S_IDLE;
                    timer_n   = '0;
                    timeout_n = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            S_CAST: begin
                state_n = S_LOCKOUT;
                timer_n = '0;
            end
            S_LOCKOUT: begin
                if (timer == LOCKOUT_LAST) begin
                    state_n = S_IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                timer_n = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_btn  <= 1'b0;
            sel         <= '0;
            ready       <= 1'b0;
            votes_cast  <= '0;
            timeout_err <= 1'b0;
            multi_err   <= 1'b0;
        end else begin
            enable_btn  <= (state_n == S_CAST);
            sel         <= sel_n;
            ready       <= (state_n == S_ARMED) || (state_n == S_SELECTED);
            timeout_err <= timeout_n;
            multi_err   <= multi_n;
            if (state_n == S_CAST) votes_cast <= votes_cast + 1'b1;
        end
    end

endmodule
